fetch_instr_decode: RTL and testbench
=====================================

Name: fetch_instr_decode

Overview:
- Y86-64 fetch-stage control decoder.
- Classifies the 4-bit instruction code (icode) from the first instruction byte and produces three combinational flags:
  - instr_valid: icode is a legal opcode.
  - need_regids: a register-specifier byte follows.
  - need_valC: an 8-byte constant follows.
- Also produces the instruction length, plus a registered copy of all results for downstream stages.
- Sits between the byte-split logic (icode/ifun) and the PC-increment / align logic.

Parameters:
- None.

Ports:
- clk            input   1  system clock, rising-edge active
- rst_n          input   1  synchronous active-low reset
- icode          input   4  instruction code (upper nibble of byte 0)
- en             input   1  capture enable for the registered outputs
- instr_valid    output  1  combinational: icode is a defined opcode
- need_regids    output  1  combinational: instruction has an rA/rB byte
- need_valC      output  1  combinational: instruction has an 8-byte constant
- instr_len      output  4  combinational: instruction length in bytes (1..10)
- instr_valid_q  output  1  registered instr_valid
- need_regids_q  output  1  registered need_regids
- need_valC_q    output  1  registered need_valC
- instr_len_q    output  4  registered instr_len

Behaviour:
- Opcode map (hex):
  - 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq
  - 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq
- Combinational outputs depend only on icode. ifun is not examined by this block.
- instr_valid = 1 for icode 0x0..0xB; 0 for 0xC..0xF.
- need_regids = 1 for icode 2, 3, 4, 5, 6, A, B; 0 otherwise, including invalid codes.
- need_valC = 1 for icode 3, 4, 5, 7, 8; 0 otherwise, including invalid codes.
- instr_len = 1 + need_regids + 8*need_valC:
  - halt/nop/ret = 1
  - rrmovq/OPq/pushq/popq = 2
  - jXX/call = 9
  - irmovq/rmmovq/mrmovq = 10
  - invalid codes = 1
- Combinational outputs settle in the same cycle icode changes, with no clock dependence. The PC-increment logic relies on this same-cycle valP.
- Registered outputs:
  - On the rising edge of clk, if rst_n==0, all *_q outputs are cleared to 0 (instr_len_q = 0). This overrides en.
  - Else if en==1, each *_q output loads its combinational counterpart.
  - Else all *_q outputs hold.
  - Latency from icode to *_q is exactly one clock edge when en=1.
- Reset is synchronous only. Asserting rst_n low between edges has no effect until the next rising edge. Combinational outputs are unaffected by reset.
- X/Z on icode: no requirement beyond simulation propagation; the decoder must be fully specified for all 16 codes (no latches).

Test Plan:
- Exhaustive sweep, rst_n=1: icode 0..15, check combinational outputs each step.
  - icode=3 -> instr_valid=1, need_regids=1, need_valC=1, instr_len=10.
  - icode=7 -> 1/0/1, len 9.
  - icode=9 -> 1/0/0, len 1.
  - icode=A -> 1/1/0, len 2.
  - icode=C..F -> 0/0/0, len 1.
- Reset: drive icode=4, en=1, rst_n=0 for one rising edge -> all *_q = 0 while combinational outputs read 1/1/1/10. Release rst_n -> next edge *_q = 1/1/1/10.
- Enable hold: load icode=6 with en=1 (*_q = 1/1/0/2), then set en=0 and icode=8 -> *_q stay 1/1/0/2 while combinational reads 1/0/1/9. Re-assert en -> *_q = 1/0/1/9 after one edge.
- Fetch walk: starting at pc=0 with sequence irmovq(3), rrmovq(2), OPq(6), jXX(7), halt(0), advance pc += instr_len -> pc goes 0, 10, 12, 14, 23, then reaches halt with len 1.
- Reset priority: rst_n=0 and en=1 on the same edge with icode=B -> *_q = 0. Mid-stream reset after several captures clears on that edge only.
- Invalid opcode: icode=F with en=1 -> instr_valid=0 combinationally and instr_valid_q=0 after the edge, with need flags 0 and len 1.

Source files
------------

// File: rtl/fetch_instr_decode.sv
// Y86-64 fetch-stage control decoder.
// Classifies icode into valid / register-byte / constant flags and the
// instruction length. The flags are produced combinationally so the PC
// increment logic can form valP in the same cycle. A registered copy of
// all four results is kept for the downstream stages.
module fetch_instr_decode (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] icode,
  input  logic       en,
  output logic       instr_valid,
  output logic       need_regids,
  output logic       need_valC,
  output logic [3:0] instr_len,
  output logic       instr_valid_q,
  output logic       need_regids_q,
  output logic       need_valC_q,
  output logic [3:0] instr_len_q
);

  // Opcode encodings (upper nibble of instruction byte 0).
  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  // Next-state values of the registered outputs.
  logic       instrValid_d;
  logic       needRegids_d;
  logic       needValC_d;
  logic [3:0] instrLen_d;

  // Decode icode into the three classification flags; every code is covered.
  always_comb begin
    instrValid_d = 1'b0;
    needRegids_d = 1'b0;
    needValC_d   = 1'b0;
    case (icode)
      IHALT, INOP, IRET: begin
        instrValid_d = 1'b1;
      end
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
        instrValid_d = 1'b1;
        needRegids_d = 1'b1;
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        instrValid_d = 1'b1;
        needRegids_d = 1'b1;
        needValC_d   = 1'b1;
      end
      IJXX, ICALL: begin
        instrValid_d = 1'b1;
        needValC_d   = 1'b1;
      end
      default: begin
        instrValid_d = 1'b0;
        needRegids_d = 1'b0;
        needValC_d   = 1'b0;
      end
    endcase
  end

  // Length = opcode byte + optional register byte + optional 8-byte constant.
  always_comb begin
    instrLen_d = 4'd1 + {3'b000, needRegids_d} + {needValC_d, 3'b000};
  end

  assign instr_valid = instrValid_d;
  assign need_regids = needRegids_d;
  assign need_valC   = needValC_d;
  assign instr_len   = instrLen_d;

  // Capture the decode results; synchronous reset takes priority over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_valid_q <= 1'b0;
      need_regids_q <= 1'b0;
      need_valC_q   <= 1'b0;
      instr_len_q   <= 4'd0;
    end else if (en) begin
      instr_valid_q <= instrValid_d;
      need_regids_q <= needRegids_d;
      need_valC_q   <= needValC_d;
      instr_len_q   <= instrLen_d;
    end
  end

endmodule

// File: tb/tb_fetch_instr_decode.sv
// Directed bench for the Y86-64 fetch-stage control decoder.
module tb_fetch_instr_decode;

  logic       clk;
  logic       rst_n;
  logic [3:0] icode;
  logic       en;
  logic       instr_valid;
  logic       need_regids;
  logic       need_valC;
  logic [3:0] instr_len;
  logic       instr_valid_q;
  logic       need_regids_q;
  logic       need_valC_q;
  logic [3:0] instr_len_q;

  int errorCount;
  int checkCount;

  // Packed views {valid, regids, valC, len} for compact comparisons.
  logic [6:0] combVec;
  logic [6:0] regVec;
  assign combVec = {instr_valid, need_regids, need_valC, instr_len};
  assign regVec  = {instr_valid_q, need_regids_q, need_valC_q, instr_len_q};

  fetch_instr_decode dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icode         (icode),
    .en            (en),
    .instr_valid   (instr_valid),
    .need_regids   (need_regids),
    .need_valC     (need_valC),
    .instr_len     (instr_len),
    .instr_valid_q (instr_valid_q),
    .need_regids_q (need_regids_q),
    .need_valC_q   (need_valC_q),
    .instr_len_q   (instr_len_q)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge, then move away from it before sampling.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  // Reset clears *_q while combinational outputs stay live; release loads.
  task automatic test_reset();
    icode = 4'h4;
    en    = 1'b1;
    rst_n = 1'b0;
    stepEdge();
    checkCount++;
    if (regVec !== 7'b000_0000) begin
      errorCount++;
      $display("[TB] FAIL reset_q: got %b expected %b", regVec, 7'b000_0000);
    end
    checkCount++;
    if (combVec !== {3'b111, 4'd10}) begin
      errorCount++;
      $display("[TB] FAIL reset_comb: got %b expected %b", combVec, {3'b111, 4'd10});
    end
    rst_n = 1'b1;
    stepEdge();
    checkCount++;
    if (regVec !== {3'b111, 4'd10}) begin
      errorCount++;
      $display("[TB] FAIL reset_release_q: got %b expected %b", regVec, {3'b111, 4'd10});
    end
  endtask

  // Exhaustive sweep of all 16 icodes against a hand-written table.
  task automatic test_sweep();
    logic [15:0] validTab;
    logic [15:0] regidsTab;
    logic [15:0] valCTab;
    logic [3:0]  lenTab [16];
    logic [6:0]  expVec;
    validTab  = 16'b0000_1111_1111_1111;
    regidsTab = 16'b0000_1100_0111_1100;
    valCTab   = 16'b0000_0001_1011_1000;
    lenTab    = '{4'd1, 4'd1, 4'd2, 4'd10, 4'd10, 4'd10, 4'd2, 4'd9,
                  4'd9, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < 16; i++) begin
      icode = 4'(i);
      #1;
      expVec = {validTab[i], regidsTab[i], valCTab[i], lenTab[i]};
      checkCount++;
      if (combVec !== expVec) begin
        errorCount++;
        $display("[TB] FAIL sweep_icode_%0h: got %b expected %b", i, combVec, expVec);
      end
    end
  endtask

  // en=0 holds *_q while the combinational side follows icode.
  task automatic test_enable_hold();
    icode = 4'h6;
    en    = 1'b1;
    stepEdge();
    checkCount++;
    if (regVec !== {3'b110, 4'd2}) begin
      errorCount++;
      $display("[TB] FAIL hold_load: got %b expected %b", regVec, {3'b110, 4'd2});
    end
    en    = 1'b0;
    icode = 4'h8;
    stepEdge();
    stepEdge();
    checkCount++;
    if (regVec !== {3'b110, 4'd2}) begin
      errorCount++;
      $display("[TB] FAIL hold_q: got %b expected %b", regVec, {3'b110, 4'd2});
    end
    checkCount++;
    if (combVec !== {3'b101, 4'd9}) begin
      errorCount++;
      $display("[TB] FAIL hold_comb: got %b expected %b", combVec, {3'b101, 4'd9});
    end
    en = 1'b1;
    stepEdge();
    checkCount++;
    if (regVec !== {3'b101, 4'd9}) begin
      errorCount++;
      $display("[TB] FAIL hold_reenable: got %b expected %b", regVec, {3'b101, 4'd9});
    end
  endtask

  // Walk a small program, advancing pc by the same-cycle length.
  task automatic test_fetch_walk();
    logic [3:0] progCodes [5];
    int         expPc [5];
    int         pc;
    progCodes = '{4'h3, 4'h2, 4'h6, 4'h7, 4'h0};
    expPc     = '{0, 10, 12, 14, 23};
    pc = 0;
    for (int i = 0; i < 5; i++) begin
      icode = progCodes[i];
      #1;
      checkCount++;
      if (pc != expPc[i]) begin
        errorCount++;
        $display("[TB] FAIL walk_pc_%0d: got %0d expected %0d", i, pc, expPc[i]);
      end
      pc = pc + int'(instr_len);
    end
    checkCount++;
    if (instr_len !== 4'd1) begin
      errorCount++;
      $display("[TB] FAIL walk_halt_len: got %0d expected 1", instr_len);
    end
  endtask

  // Reset beats enable; mid-stream reset acts only on its edge.
  task automatic test_reset_priority();
    icode = 4'hB;
    en    = 1'b1;
    rst_n = 1'b1;
    stepEdge();
    icode = 4'h5;
    stepEdge();
    checkCount++;
    if (regVec !== {3'b111, 4'd10}) begin
      errorCount++;
      $display("[TB] FAIL prio_capture: got %b expected %b", regVec, {3'b111, 4'd10});
    end
    icode = 4'hB;
    rst_n = 1'b0;
    #2;
    checkCount++;
    if (regVec !== {3'b111, 4'd10}) begin
      errorCount++;
      $display("[TB] FAIL prio_async_no_effect: got %b expected %b", regVec, {3'b111, 4'd10});
    end
    stepEdge();
    checkCount++;
    if (regVec !== 7'b000_0000) begin
      errorCount++;
      $display("[TB] FAIL prio_reset_over_en: got %b expected %b", regVec, 7'b000_0000);
    end
    rst_n = 1'b1;
    stepEdge();
    checkCount++;
    if (regVec !== {3'b110, 4'd2}) begin
      errorCount++;
      $display("[TB] FAIL prio_after_release: got %b expected %b", regVec, {3'b110, 4'd2});
    end
  endtask

  // Undefined opcode decodes to invalid with length 1.
  task automatic test_invalid();
    icode = 4'hF;
    en    = 1'b1;
    #1;
    checkCount++;
    if (combVec !== {3'b000, 4'd1}) begin
      errorCount++;
      $display("[TB] FAIL invalid_comb: got %b expected %b", combVec, {3'b000, 4'd1});
    end
    stepEdge();
    checkCount++;
    if (regVec !== {3'b000, 4'd1}) begin
      errorCount++;
      $display("[TB] FAIL invalid_q: got %b expected %b", regVec, {3'b000, 4'd1});
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    errorCount = 0;
    checkCount = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    icode = 4'h0;
    #1;
    test_reset();
    test_sweep();
    test_enable_hold();
    test_fetch_walk();
    test_reset_priority();
    test_invalid();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
